// File: rtl/msg_pkg.sv
// Shared types and defaults for the UART command frame parser.
package msg_pkg;

    localparam logic [7:0] HDR_WR_DEF = 8'h5A;
    localparam logic [7:0] HDR_RD_DEF = 8'h5B;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StCsum,
        StTail,
        StIssue,
        StError
    } state_e;

    typedef enum logic [1:0] {
        ErrNone,
        ErrTail,
        ErrTimeout,
        ErrCsum
    } err_cause_e;

endpackage

// File: rtl/msg_timeout_timer.sv
// Frame timeout counter: counts TICK strobes while running and flags when the
// budget is used up. Holds at TIMEOUT_TICKS until cleared. TIMEOUT_TICKS >= 1.
module msg_timeout_timer #(
    parameter int unsigned TIMEOUT_TICKS = 200,
    parameter int unsigned CNT_W         = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    assign hit = (count == CNT_W'(TIMEOUT_TICKS));

    // Count ticks while running, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && tick && !hit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/msg_frame_rx.sv
// UART command frame parser: pops bytes from a FWFT RX FIFO, validates
// header/address/data/tail and raises one held OPB write or read request per
// frame. Define MSG_CHECKSUM_EN to insert an XOR checksum byte before the tail.
module msg_frame_rx
    import msg_pkg::*;
#(
    parameter int unsigned ADDR_BYTES    = 4,
    parameter int unsigned DATA_BYTES    = 4,
    parameter logic [7:0]  HDR_WR        = HDR_WR_DEF,
    parameter logic [7:0]  HDR_RD        = HDR_RD_DEF,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic                    OPB_CLK,
    input  logic                    OPB_RST,
    input  logic                    TICK,
    output logic                    RX_FIFO_RD,
    input  logic [7:0]              RX_FIFO_DATA,
    input  logic                    RX_FIFO_EMPTY,
    output logic [8*ADDR_BYTES-1:0] OPB_ADDR,
    output logic [8*DATA_BYTES-1:0] OPB_DO,
    output logic                    OPB_WE,
    output logic                    OPB_RE,
    input  logic                    OPB_XFER_ACK,
    output logic                    ERR_TAIL,
    output logic                    ERR_TIMEOUT,
    output logic                    ERR_CSUM,
    output logic [15:0]             ERR_CNT,
    output logic [15:0]             FRAME_CNT
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_TICKS + 1);

    state_e                  state_q, state_d;
    err_cause_e              cause_q, cause_d;
    logic [1:0]              byte_cnt_q;
    logic                    hdr_wr_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [8*DATA_BYTES-1:0] data_q;
    logic [15:0]             err_cnt_q, frame_cnt_q;
    logic                    in_frame, timeout_hit, accept;
    logic                    addr_last, data_last, is_hdr;
    logic [7:0]              tail_exp;
    logic [TMR_W-1:0]        unused_timer_count;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    assign in_frame  = state_q inside {StAddr, StData, StCsum, StTail, StIssue};
    assign accept    = RX_FIFO_RD;
    assign addr_last = (byte_cnt_q == 2'(ADDR_BYTES - 1));
    assign data_last = (byte_cnt_q == 2'(DATA_BYTES - 1));
    assign is_hdr    = (RX_FIFO_DATA == HDR_WR) || (RX_FIFO_DATA == HDR_RD);
    assign tail_exp  = hdr_wr_q ? ~HDR_WR : ~HDR_RD;

    // Cleared outside a frame so a header can be taken on the first IDLE cycle
    msg_timeout_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .CNT_W         (TMR_W)
    ) u_timer (
        .clk   (OPB_CLK),
        .rst   (OPB_RST),
        .clear (!in_frame),
        .run   (in_frame),
        .tick  (TICK),
        .count (unused_timer_count),
        .hit   (timeout_hit)
    );

    // State and error-cause registers
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= StIdle;
            cause_q <= ErrNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state decode; a timeout overrides any byte or ACK in the same cycle
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if (in_frame && timeout_hit) begin
            state_d = StError;
            cause_d = ErrTimeout;
        end else begin
            case (state_q)
                StIdle:  if (accept && is_hdr) state_d = StAddr;
                StAddr:  if (accept && addr_last) state_d = StData;
`ifdef MSG_CHECKSUM_EN
                StData:  if (accept && data_last) state_d = StCsum;
                StCsum: begin
                    if (accept) begin
                        if (RX_FIFO_DATA == csum_q) begin
                            state_d = StTail;
                        end else begin
                            state_d = StError;
                            cause_d = ErrCsum;
                        end
                    end
                end
`else
                StData:  if (accept && data_last) state_d = StTail;
`endif
                StTail: begin
                    if (accept) begin
                        if (RX_FIFO_DATA == tail_exp) begin
                            state_d = StIssue;
                        end else begin
                            state_d = StError;
                            cause_d = ErrTail;
                        end
                    end
                end
                StIssue: if (OPB_XFER_ACK) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Frame datapath: byte counter, header kind, big-endian address/data shift
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            byte_cnt_q <= '0;
            hdr_wr_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (state_q == StIdle) begin
                byte_cnt_q <= '0;
            end else if (accept) begin
                byte_cnt_q <= (state_d != state_q) ? 2'd0 : byte_cnt_q + 2'd1;
            end
            if (accept && state_q == StIdle && is_hdr) begin
                hdr_wr_q <= (RX_FIFO_DATA == HDR_WR);
            end
            if (accept && state_q == StAddr) begin
                addr_q <= (addr_q << 8) | (8 * ADDR_BYTES)'(RX_FIFO_DATA);
            end
            if (accept && state_q == StData) begin
                data_q <= (data_q << 8) | (8 * DATA_BYTES)'(RX_FIFO_DATA);
            end
        end
    end

`ifdef MSG_CHECKSUM_EN
    // Running XOR over header, address and data bytes
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            csum_q <= '0;
        end else if (accept && state_q == StIdle && is_hdr) begin
            csum_q <= RX_FIFO_DATA;
        end else if (accept && (state_q == StAddr || state_q == StData)) begin
            csum_q <= csum_q ^ RX_FIFO_DATA;
        end
    end
`endif

    // Completed-request (wrapping) and error (saturating) counters
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (state_q == StIssue && state_d == StIdle) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state_q == StError && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        RX_FIFO_RD  = !OPB_RST && !RX_FIFO_EMPTY && !timeout_hit &&
                      (state_q inside {StIdle, StAddr, StData, StCsum, StTail});
        OPB_WE      = (state_q == StIssue) && hdr_wr_q;
        OPB_RE      = (state_q == StIssue) && !hdr_wr_q;
        ERR_TAIL    = (state_q == StError) && (cause_q == ErrTail);
        ERR_TIMEOUT = (state_q == StError) && (cause_q == ErrTimeout);
`ifdef MSG_CHECKSUM_EN
        ERR_CSUM    = (state_q == StError) && (cause_q == ErrCsum);
`else
        ERR_CSUM    = 1'b0;
`endif
    end

    assign OPB_ADDR  = addr_q;
    assign OPB_DO    = data_q;
    assign ERR_CNT   = err_cnt_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule
